sll_pipe: RTL and testbench

Pipelined 32-bit logical left shifter for the RV32I ALU, covering SLL/SLLI. It is the left-shift counterpart of the combinational logical right shifter and uses the same 16/8/4/2/1 decomposition. Each decomposition step is registered as one pipeline stage. Operands enter with a scoreboard tag, and the tag returns with the result so the scoreboard can retire the destination register. Valid/ready handshakes on both sides give full throughput and per-stage bubble collapsing; a flush kills all in-flight operations.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/sll_stage.sv | 44 ++++
 rtl/sll_pipe.sv | 75 +++++++
 tb/tb_sll_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the pipelined logical left shifter:
// operand widths, per-stage shift distances and the stage register layout.
package alu_pkg;

  localparam int XLEN      = 32;
  localparam int SHAMT_W   = 5;
  localparam int STAGES    = 5;
  localparam int SLL_TAG_W = 5;

  localparam int SH_S1 = 16;
  localparam int SH_S2 = 8;
  localparam int SH_S3 = 4;
  localparam int SH_S4 = 2;
  localparam int SH_S5 = 1;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      data;
    logic [SHAMT_W-1:0]   shamt_rem;
    logic [SLL_TAG_W-1:0] tag;
  } sll_stage_t;

  function automatic int stage_shift(input int k);
    case (k)
      1:       return SH_S1;
      2:       return SH_S2;
      3:       return SH_S3;
      4:       return SH_S4;
      5:       return SH_S5;
      default: return 0;
    endcase
  endfunction

  // Zero-filling constant left shift, applied only when the stage's shamt bit is set.
  function automatic logic [XLEN-1:0] sll_const(input logic [XLEN-1:0] d,
                                                input int sh,
                                                input logic en);
    return en ? (d << sh) : d;
  endfunction

endpackage

// File: rtl/sll_stage.sv
// One register stage of the left shifter: conditional constant shift by SHIFT
// when shamt bit BIT is set, plus the stage's local ready term.
module sll_stage
  import alu_pkg::*;
#(
  parameter int SHIFT = 1,
  parameter int BIT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  sll_stage_t prev,
  input  logic       nxt_rdy,
  output logic       rdy,
  output sll_stage_t stage_q
);

  sll_stage_t         stage_p;
  logic [SHAMT_W-1:0] rem_next;

  // An empty stage can always load, which is what collapses bubbles under stall.
  assign rdy = !stage_p.valid || nxt_rdy;

  always_comb begin
    rem_next      = prev.shamt_rem;
    rem_next[BIT] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_p <= '0;
    end else if (flush) begin
      stage_p.valid <= 1'b0;
    end else if (rdy) begin
      stage_p.valid     <= prev.valid;
      stage_p.data      <= sll_const(prev.data, SHIFT, prev.shamt_rem[BIT]);
      stage_p.shamt_rem <= rem_next;
      stage_p.tag       <= prev.tag;
    end
  end

  assign stage_q = stage_p;

endmodule

// File: rtl/sll_pipe.sv
// Five-stage pipelined 32-bit logical left shifter (SLL/SLLI) with a tag
// carried alongside each operand and valid/ready handshakes on both ends.
module sll_pipe
  import alu_pkg::*;
#(
  parameter int TAG_W = SLL_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [TAG_W-1:0]   out_tag
);

  sll_stage_t        s_in;
  sll_stage_t        stq [1:STAGES];
  logic [STAGES:1]   down_rdy;
  logic [STAGES:1]   stage_rdy;
  logic              unused_tail;

  assign in_ready = stage_rdy[1] && !flush && !rst;

  assign s_in = '{valid:     in_valid && in_ready,
                  data:      in_a,
                  shamt_rem: in_shamt,
                  tag:       in_tag};

  // Ready seen by each stage from downstream, unrolled from the output back.
  always_comb begin
    logic r;
    r        = out_ready;
    down_rdy = '0;
    for (int k = STAGES; k >= 1; k--) begin
      down_rdy[k] = r;
      r           = !stq[k].valid || r;
    end
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    sll_stage_t prev;

    if (k == 1) begin : g_src
      assign prev = s_in;
    end else begin : g_src
      assign prev = stq[k-1];
    end

    sll_stage #(
      .SHIFT (stage_shift(k)),
      .BIT   (STAGES - k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .prev    (prev),
      .nxt_rdy (down_rdy[k]),
      .rdy     (stage_rdy[k]),
      .stage_q (stq[k])
    );
  end

  assign out_valid  = stq[STAGES].valid && !flush && !rst;
  assign out_result = stq[STAGES].data;
  assign out_tag    = stq[STAGES].tag;

  assign unused_tail = ^{stq[STAGES].shamt_rem, stage_rdy[STAGES:2]};

endmodule

// File: tb/tb_sll_pipe.sv
// Self-checking bench for sll_pipe: directed and random operands scored
// against a queue of expected a<<shamt results in acceptance order.
module tb_sll_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   lat_chk = 0;

  sll_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // One cycle: score outputs and accepted inputs, then advance to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst && !flush) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          e = q[0];
          chk("result", out_result, e.res);
          chk("tag", out_tag, e.tag);
          if (out_ready) begin
            if (lat_chk) chk("latency", cyc - e.acc, 5);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back('{res: in_a << in_shamt, tag: in_tag, acc: cyc});
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [31:0] a, input logic [4:0] sh, input logic [4:0] tg);
    in_valid = 1'b1;
    in_a     = a;
    in_shamt = sh;
    in_tag   = tg;
    #1;
    chk("send_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    int  idx;
    bit  acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_shamt = '0; in_tag = '0;
    @(negedge clk);

    // Reset state
    tick();
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_tag", out_tag, 5'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Single ops and boundaries with exact latency
    lat_chk = 1;
    send(32'h0000_0001, 5'd31, 5'd7);  drain();
    send(32'hFFFF_FFFF, 5'd4,  5'd1);  drain();
    send(32'hDEAD_BEEF, 5'd0,  5'd2);  drain();
    send(32'h1234_5678, 5'd16, 5'd3);  drain();
    send(32'hFFFF_FFFF, 5'd31, 5'd4);  drain();

    // Back-to-back stream of every shift amount
    for (int i = 0; i < 32; i++) send(32'hA5A5_A5A5, 5'(i), 5'(i));
    drain();

    // Random traffic with random backpressure
    lat_chk = 0;
    for (int i = 0; i < 120; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = $urandom;
      in_shamt  = 5'($urandom);
      in_tag    = 5'($urandom);
      tick();
    end
    drain();

    // Backpressure: fill the pipe, then drain while accepting the rest
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1; in_a = $urandom; in_shamt = 5'($urandom); in_tag = 5'(idx);
      #1;
      chk("bp_in_ready", in_ready, (c < 5));
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_stall_valid", out_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 7); in_a = $urandom; in_shamt = 5'($urandom); in_tag = 5'(idx);
      #1;
      chk("bp_drain_valid", out_valid, 1'b1);
      if (c < 2) chk("bp_drain_in_ready", in_ready, 1'b1);
      acc = in_ready && in_valid;
      tick();
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 7);
    drain();

    // Flush with three ops in flight
    lat_chk = 1;
    for (int i = 0; i < 3; i++) send($urandom, 5'($urandom), 5'(i + 10));
    flush = 1'b1; in_valid = 1'b1; in_a = $urandom; in_shamt = 5'd3; in_tag = 5'd20;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    chk("flush_out_valid", out_valid, 1'b0);
    tick();
    q.delete();
    flush = 1'b0; in_valid = 1'b0;
    send(32'h0000_00FF, 5'd8, 5'd21);
    drain();
    repeat (6) tick();

    // Reset with four ops in flight
    for (int i = 0; i < 4; i++) send($urandom, 5'($urandom), 5'(i + 24));
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    tick();
    q.delete();
    rst = 1'b0;
    #1;
    chk("after_rst_out_valid", out_valid, 1'b0);
    chk("after_rst_out_result", out_result, 32'h0);
    chk("after_rst_out_tag", out_tag, 5'd0);
    chk("after_rst_in_ready", in_ready, 1'b1);
    repeat (10) tick();
    send(32'h8000_0001, 5'd1, 5'd30);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
